// File: rtl/pad_out_serializer.sv
// Pad-side output serializer: DEPTH-entry FIFO feeding an MSB-first, LANES-wide
// beat shifter. Define PAD_OUT_PARITY_EN to append an even-parity beat per word.
module pad_out_serializer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [LANES-1:0]           out_value,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int BEATS  = DATA_W / LANES;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PAD_OUT_PARITY_EN
  localparam int LAST   = BEATS;
`else
  localparam int LAST   = BEATS - 1;
`endif
  localparam int CNT_W  = (LAST > 0) ? $clog2(LAST + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  generate
    if (DATA_W % LANES != 0) begin : g_bad_lanes
      $error("pad_out_serializer: DATA_W must be a multiple of LANES");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pad_out_serializer: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [0:0]        state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              last_beat;
`ifdef PAD_OUT_PARITY_EN
  logic              par;
`endif

  // Handshake: a word transfers on an edge where in_valid && in_ready; in_ready
  // depends only on registered fill, so a full FIFO refuses even while popping.
  assign in_ready  = (fill < FILL_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign last_beat = (state == S_SEND) && (beat_cnt == CNT_W'(LAST));
  assign pop       = (fill != '0) && ((state == S_IDLE) || last_beat);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Loading a word emits beat 0 immediately; later beats come from the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
`ifdef PAD_OUT_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (pop) begin
      state     <= S_SEND;
      beat_cnt  <= '0;
      shreg     <= head << LANES;
      out_valid <= 1'b1;
      out_value <= head[DATA_W-1 -: LANES];
`ifdef PAD_OUT_PARITY_EN
      par       <= ^head;
`endif
    end else if (last_beat) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
    end else if (state == S_SEND) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
`ifdef PAD_OUT_PARITY_EN
      if (beat_cnt == CNT_W'(BEATS - 1)) begin
        out_value <= LANES'(par);
      end else begin
        out_value <= shreg[DATA_W-1 -: LANES];
        shreg     <= shreg << LANES;
      end
`else
      out_value <= shreg[DATA_W-1 -: LANES];
      shreg     <= shreg << LANES;
`endif
    end
  end

endmodule
